// File: rtl/axil_crossbar_wr_route_pkg.sv
// Shared definitions for the crossbar write data/response router.
package axil_crossbar_wr_route_pkg;

    // AXI-lite B response codes
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // W path: wait for command, take beat from slave, present beat to master
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_OUT  = 2'd2
    } w_state_e;

    // B path: wait for command, wait for response, present response to slave
    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_WAIT = 2'd1,
        B_RESP = 2'd2
    } b_state_e;

endpackage

// File: rtl/axil_crossbar_wr_route.sv
// Per-slave-interface AXI-lite write data / write response router.
// Steers one W beat per write command to the selected master and returns that
// master's B response; decode errors swallow the beat and answer DECERR.
module axil_crossbar_wr_route
    import axil_crossbar_wr_route_pkg::*;
#(
    parameter int M_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [CL_M_COUNT-1:0]   s_wc_select,
    input  logic                    s_wc_decerr,
    input  logic                    s_wc_valid,
    output logic                    s_wc_ready,

    input  logic [CL_M_COUNT-1:0]   s_rc_select,
    input  logic                    s_rc_decerr,
    input  logic                    s_rc_valid,
    output logic                    s_rc_ready,

    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,

    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
    output logic [M_COUNT-1:0]      m_axil_wvalid,
    input  logic [M_COUNT-1:0]      m_axil_wready,
    input  logic [M_COUNT*2-1:0]    m_axil_bresp,
    input  logic [M_COUNT-1:0]      m_axil_bvalid,
    output logic [M_COUNT-1:0]      m_axil_bready
);

    if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb_width
        $error("STRB_WIDTH must equal DATA_WIDTH/8");
    end

    w_state_e               w_state_q, w_state_d;
    b_state_e               b_state_q, b_state_d;
    logic [CL_M_COUNT-1:0]  w_sel_q, w_sel_d;
    logic                   w_decerr_q, w_decerr_d;
    logic [CL_M_COUNT-1:0]  b_sel_q, b_sel_d;
    logic                   b_decerr_q, b_decerr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;
    logic [1:0]             bresp_q, bresp_d;
    // Completed-but-unanswered W beats; keeps a B from overtaking its W.
    logic [1:0]             credit_q, credit_d;
    logic                   w_done;
    logic                   b_take;

    // W FSM next state and handshake outputs
    always_comb begin
        w_state_d     = w_state_q;
        w_sel_d       = w_sel_q;
        w_decerr_d    = w_decerr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        w_done        = 1'b0;
        s_wc_ready    = 1'b0;
        s_axil_wready = 1'b0;
        m_axil_wvalid = '0;
        unique case (w_state_q)
            W_IDLE: begin
                s_wc_ready = 1'b1;
                if (s_wc_valid) begin
                    w_sel_d    = s_wc_select;
                    w_decerr_d = s_wc_decerr;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                s_axil_wready = 1'b1;
                if (s_axil_wvalid) begin
                    if (w_decerr_q) begin
                        w_done    = 1'b1;
                        w_state_d = W_IDLE;
                    end else begin
                        wdata_d   = s_axil_wdata;
                        wstrb_d   = s_axil_wstrb;
                        w_state_d = W_OUT;
                    end
                end
            end
            W_OUT: begin
                m_axil_wvalid[w_sel_q] = 1'b1;
                if (m_axil_wready[w_sel_q]) begin
                    w_done    = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // Handshake outputs read as zero while reset is held
        if (rst) begin
            s_wc_ready    = 1'b0;
            s_axil_wready = 1'b0;
            m_axil_wvalid = '0;
            w_done        = 1'b0;
        end
    end

    // B FSM next state and handshake outputs
    always_comb begin
        b_state_d     = b_state_q;
        b_sel_d       = b_sel_q;
        b_decerr_d    = b_decerr_q;
        bresp_d       = bresp_q;
        b_take        = 1'b0;
        s_rc_ready    = 1'b0;
        m_axil_bready = '0;
        unique case (b_state_q)
            B_IDLE: begin
                s_rc_ready = 1'b1;
                if (s_rc_valid) begin
                    b_sel_d    = s_rc_select;
                    b_decerr_d = s_rc_decerr;
                    b_state_d  = B_WAIT;
                end
            end
            B_WAIT: begin
                if (b_decerr_q) begin
                    if (credit_q != 2'd0) begin
                        bresp_d   = BRESP_DECERR;
                        b_take    = 1'b1;
                        b_state_d = B_RESP;
                    end
                end else begin
                    m_axil_bready[b_sel_q] = 1'b1;
                    if (m_axil_bvalid[b_sel_q]) begin
                        bresp_d   = m_axil_bresp[2*b_sel_q +: 2];
                        b_take    = 1'b1;
                        b_state_d = B_RESP;
                    end
                end
            end
            B_RESP: begin
                if (s_axil_bready) begin
                    b_state_d = B_IDLE;
                end
            end
            default: b_state_d = B_IDLE;
        endcase
        if (rst) begin
            s_rc_ready    = 1'b0;
            m_axil_bready = '0;
            b_take        = 1'b0;
        end
    end

    // Credit: +1 per finished W beat, -1 per B taken, both together cancel
    always_comb begin
        credit_d = credit_q;
        if (w_done && !b_take) begin
            credit_d = credit_q + 2'd1;
        end else if (!w_done && b_take) begin
            credit_d = credit_q - 2'd1;
        end
    end

    // Registered slave-side B and shared master-side W data
    always_comb begin
        s_axil_bvalid = (b_state_q == B_RESP) && !rst;
        s_axil_bresp  = bresp_q;
        m_axil_wdata  = wdata_q;
        m_axil_wstrb  = wstrb_q;
    end

    // Control state with synchronous reset; credit bounded to 0..2
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            b_state_q <= B_IDLE;
            credit_q  <= 2'd0;
        end else begin
            assert (!(w_done && !b_take && credit_q == 2'd2));
            assert (!(b_take && !w_done && credit_q == 2'd0));
            w_state_q <= w_state_d;
            b_state_q <= b_state_d;
            credit_q  <= credit_d;
        end
    end

    // Datapath and command fields, intentionally not reset
    always_ff @(posedge clk) begin
        w_sel_q    <= w_sel_d;
        w_decerr_q <= w_decerr_d;
        b_sel_q    <= b_sel_d;
        b_decerr_q <= b_decerr_d;
        wdata_q    <= wdata_d;
        wstrb_q    <= wstrb_d;
        bresp_q    <= bresp_d;
    end

endmodule
